// File: rtl/multiplier_unit.sv
// Multi-cycle unsigned multiply unit for the Tomasulo core: accepts a tagged
// operand pair when idle and broadcasts the truncated product with its tag for one cycle.
module multiplier_unit #(
  parameter int WIDTH   = 8,
  parameter int TAG_W   = 3,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [TAG_W-1:0] MUL_Tag_ip,
  input  logic [WIDTH-1:0] Source_Reg1,
  input  logic [WIDTH-1:0] Source_Reg2,
  output logic [2:0]       count,
  output logic             MUL_Status,
  output logic [WIDTH-1:0] MUL_Output,
  output logic [TAG_W-1:0] MUL_Tag_op
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BUSY  = 1'b1;
  localparam logic [2:0] LAT_C = 3'(LATENCY);

  logic [0:0]       state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [TAG_W-1:0] tag_op_q, tag_op_d;

  // Low WIDTH bits of an unsigned product depend only on the operands' low bits,
  // so evaluating in WIDTH context equals truncating the full 2*WIDTH product.
  function automatic logic [WIDTH-1:0] mul_trunc(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] p;
    p = x * y;
    return p;
  endfunction

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    out_d    = out_q;
    tag_op_d = '0;
    if (state_q == IDLE) begin
      count_d = 3'd0;
      if (MUL_Tag_ip != '0) begin
        a_d     = Source_Reg1;
        b_d     = Source_Reg2;
        tag_d   = MUL_Tag_ip;
        count_d = 3'd1;
        state_d = BUSY;
      end
    end else if (count_q < LAT_C) begin
      count_d = count_q + 3'd1;
    end else begin
      out_d    = mul_trunc(a_q, b_q);
      tag_op_d = tag_q;
      count_d  = 3'd0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      out_q    <= '0;
      tag_op_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      out_q    <= out_d;
      tag_op_q <= tag_op_d;
    end
  end

  assign count      = count_q;
  assign MUL_Status = (state_q == BUSY);
  assign MUL_Output = out_q;
  assign MUL_Tag_op = tag_op_q;

endmodule

// File: tb/tb_multiplier_unit.sv
// Bench for multiplier_unit: directed vectors, multi-cycle corner sequences and
// randomized traffic against an edge-counting reference model.
module tb_multiplier_unit;
  localparam int WIDTH   = 8;
  localparam int TAG_W   = 3;
  localparam int LATENCY = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [TAG_W-1:0] tag_ip = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       count;
  logic             status;
  logic [WIDTH-1:0] out;
  logic [TAG_W-1:0] tag_op;

  multiplier_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset_n(reset_n), .MUL_Tag_ip(tag_ip),
    .Source_Reg1(a), .Source_Reg2(b), .count(count),
    .MUL_Status(status), .MUL_Output(out), .MUL_Tag_op(tag_op)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an operation issued on edge N completes on edge N+LATENCY.
  int               edge_n = 0;
  int               m_issue = 0;
  bit               m_busy = 0;
  int               m_count = 0;
  int unsigned      m_a = 0, m_b = 0;
  logic [TAG_W-1:0] m_tag = '0, m_tagop = '0;
  logic [WIDTH-1:0] m_out = '0;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [TAG_W-1:0] vtag;
    logic [WIDTH-1:0] vexp;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_count = 0; m_out = '0; m_tagop = '0; m_tag = '0;
  endtask

  task automatic model_edge();
    edge_n++;
    m_tagop = '0;
    if (m_busy) begin
      if (edge_n - m_issue == LATENCY) begin
        m_out   = WIDTH'((m_a * m_b) % (1 << WIDTH));
        m_tagop = m_tag;
        m_busy  = 0;
      end
    end else if (tag_ip != '0) begin
      m_busy = 1; m_issue = edge_n; m_a = a; m_b = b; m_tag = tag_ip;
    end
    m_count = m_busy ? (edge_n - m_issue + 1) : 0;
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(m_count));
    check("status", 32'(status), 32'(m_busy));
    check("output", 32'(out), 32'(m_out));
    check("tag_op", 32'(tag_op), 32'(m_tagop));
  endtask

  task automatic tick(input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] y);
    tag_ip = t; a = x; b = y;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    vecs[0] = '{8'd16,  8'd32,  3'd1, 8'h00};
    vecs[1] = '{8'd255, 8'd255, 3'd3, 8'h01};
    vecs[2] = '{8'd0,   8'd77,  3'd5, 8'd0};
    vecs[3] = '{8'd77,  8'd0,   3'd6, 8'd0};
    vecs[4] = '{8'd13,  8'd11,  3'd7, 8'd143};
    vecs[5] = '{8'd200, 8'd3,   3'd4, 8'd88};
    vecs[6] = '{8'd15,  8'd17,  3'd2, 8'd255};

    // Reset state
    #12;
    model_reset();
    check_all();
    @(negedge clk) reset_n = 1'b1;

    // Null tag held with live operands
    repeat (8) tick('0, 8'd5, 8'd2);
    check("null_status", 32'(status), 32'd0);

    // Basic: 1*15 with tag 2
    tick(3'b010, 8'd1, 8'd15);
    check("basic_cnt1", 32'(count), 32'd1);
    repeat (3) tick('0, '0, '0);
    check("basic_cnt4", 32'(count), 32'd4);
    tick('0, '0, '0);
    check("basic_out", 32'(out), 32'd15);
    check("basic_tag", 32'(tag_op), 32'b010);
    check("basic_idle", 32'(status), 32'd0);
    tick('0, '0, '0);
    check("basic_tag_clr", 32'(tag_op), 32'd0);

    // Directed vectors incl. truncation and zero operands
    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].vtag, vecs[i].va, vecs[i].vb);
      repeat (LATENCY - 1) tick('0, '0, '0);
      tick('0, '0, '0);
      check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].vexp));
      check($sformatf("vec%0d_tag", i), 32'(tag_op), 32'(vecs[i].vtag));
      tick('0, '0, '0);
    end

    // Busy ignore: new request at count=2 is dropped
    tick(3'b001, 8'd5, 8'd2);
    tick('0, '0, '0);
    tick(3'b011, 8'd3, 8'd3);
    tick('0, '0, '0);
    tick('0, '0, '0);
    check("busy_out", 32'(out), 32'd10);
    check("busy_tag", 32'(tag_op), 32'b001);
    repeat (6) begin
      tick('0, '0, '0);
      check("busy_no_second", 32'(tag_op), 32'd0);
    end

    // Back-to-back issue on the edge after completion
    tick(3'd4, 8'd6, 8'd7);
    repeat (3) tick('0, '0, '0);
    tick('0, '0, '0);
    check("b2b_first_tag", 32'(tag_op), 32'd4);
    tick(3'd5, 8'd9, 8'd9);
    check("b2b_accept", 32'(status), 32'd1);
    check("b2b_tag_clr", 32'(tag_op), 32'd0);
    check("b2b_hold_out", 32'(out), 32'd42);
    repeat (LATENCY - 1) tick('0, '0, '0);
    tick('0, '0, '0);
    check("b2b_second_out", 32'(out), 32'd81);
    check("b2b_second_tag", 32'(tag_op), 32'd5);

    // Asynchronous reset mid-operation
    tick(3'd6, 8'd3, 8'd4);
    tick('0, '0, '0);
    check("rst_pre_cnt", 32'(count), 32'd2);
    #3 reset_n = 1'b0;
    #1;
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_tag", 32'(tag_op), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk) reset_n = 1'b1;
    repeat (LATENCY + 3) tick('0, '0, '0);

    // Randomized traffic, including tags held while busy
    for (int i = 0; i < 400; i++) begin
      logic [TAG_W-1:0] t;
      t = ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 7)) : '0;
      tick(t, WIDTH'($urandom), WIDTH'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
